// File: rtl/glyph_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : glyph_line_fetcher
// Description : Fetches one glyph row per digit slot from a shared glyph ROM
//               during horizontal blanking, then serialises it to pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_line_fetcher #(
    parameter int NUM_DIGITS = 4,
    parameter int GLYPH_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_start,
    input  logic                    line_active,
    input  logic [2:0]              row_sel,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [3:0]              rom_digit,
    output logic [2:0]              rom_row,
    input  logic [GLYPH_W-1:0]      rom_code,
    input  logic                    pix_en,
    output logic                    pix_out,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_DW = $clog2(NUM_DIGITS + 1);
    localparam int c_CW = $clog2(GLYPH_W + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_READY = 2'd2;

    localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(NUM_DIGITS - 1);
    localparam logic [c_DW-1:0] c_END_DIG    = c_DW'(NUM_DIGITS);
    localparam logic [c_CW-1:0] c_SPACER_COL = c_CW'(GLYPH_W);

    logic [1:0]         r_state;
    logic [c_IW-1:0]    r_idx;
    logic [2:0]         r_row;
    logic [c_DW-1:0]    r_dig;
    logic [c_CW-1:0]    r_col;
    logic [GLYPH_W-1:0] r_buf [NUM_DIGITS];
    logic               r_pix_out;
    logic               r_busy;
    logic               r_done;
    logic               r_underrun;

    logic [3:0]         w_slot_digit;
    logic [GLYPH_W-1:0] w_cur_glyph;
    logic               w_cur_bit;

    always_comb begin
        w_slot_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IW'(i)) w_slot_digit = digit_val[4*i +: 4];
        end
    end

    // Pixel selection only matters while r_dig/r_col are in range; the
    // out-of-range cases are handled explicitly in the sequential block.
    always_comb begin
        w_cur_glyph = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig == c_DW'(i)) w_cur_glyph = r_buf[i];
        end
        w_cur_bit = 1'b0;
        for (int j = 0; j < GLYPH_W; j++) begin
            if (r_col == c_CW'(j)) w_cur_bit = w_cur_glyph[GLYPH_W-1-j];
        end
    end

    assign rom_digit = (r_state == c_ST_FETCH) ? w_slot_digit : 4'd0;
    assign rom_row   = (r_state == c_ST_FETCH) ? r_row : 3'd0;
    assign pix_out   = r_pix_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underrun  = r_underrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= '0;
            r_row      <= 3'd0;
            r_dig      <= '0;
            r_col      <= '0;
            r_pix_out  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == c_ST_FETCH) && pix_en) r_underrun <= 1'b1;

            // A new line always wins, including over a same-cycle pixel strobe.
            if (line_start) begin
                r_row     <= row_sel;
                r_idx     <= '0;
                r_dig     <= '0;
                r_col     <= '0;
                r_pix_out <= 1'b0;
                if (line_active) begin
                    r_state <= c_ST_FETCH;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= c_ST_READY;
                    r_busy  <= 1'b0;
                    for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= '0;
                end
            end else begin
                case (r_state)
                    c_ST_FETCH: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (r_idx == c_IW'(i)) r_buf[i] <= rom_code;
                        end
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_ST_READY;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    c_ST_READY: begin
                        if (pix_en) begin
                            if (r_dig == c_END_DIG) begin
                                r_pix_out <= 1'b0;
                            end else if (r_col == c_SPACER_COL) begin
                                r_pix_out <= 1'b0;
                                r_col     <= '0;
                                r_dig     <= r_dig + 1'b1;
                            end else begin
                                r_pix_out <= w_cur_bit;
                                r_col     <= r_col + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glyph_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_glyph_line_fetcher
// Description : Directed self-checking bench for glyph_line_fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_line_fetcher;

    logic        clk;
    logic        rst_n;
    logic        line_start;
    logic        line_active;
    logic [2:0]  row_sel;
    logic [15:0] digit_val;
    logic [3:0]  rom_digit;
    logic [2:0]  rom_row;
    logic [4:0]  rom_code;
    logic        pix_en;
    logic        pix_out;
    logic        busy;
    logic        done;
    logic        underrun;

    int checks;
    int failures;

    glyph_line_fetcher #(.NUM_DIGITS(4), .GLYPH_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_start  (line_start),
        .line_active (line_active),
        .row_sel     (row_sel),
        .digit_val   (digit_val),
        .rom_digit   (rom_digit),
        .rom_row     (rom_row),
        .rom_code    (rom_code),
        .pix_en      (pix_en),
        .pix_out     (pix_out),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM model: row 2 encodes the digit code so slot order is visible.
    always_comb begin
        case (rom_row)
            3'd0:    rom_code = 5'b01110;
            3'd1:    rom_code = 5'b10001;
            3'd2:    rom_code = {1'b1, rom_digit};
            default: rom_code = 5'b11111;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_line(input logic act, input logic [2:0] row, input logic [15:0] dv);
        line_start  = 1'b1;
        line_active = act;
        row_sel     = row;
        digit_val   = dv;
        step();
        line_start  = 1'b0;
    endtask

    // Pulse pix_en once, check the new pixel, then check it holds for a cycle.
    task automatic pixel(input string tag, input logic exp);
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        check(tag, pix_out, exp);
        step();
        check({tag, "_hold"}, pix_out, exp);
    endtask

    logic [23:0] pat_row0;
    logic [23:0] pat_row2;

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        line_start  = 1'b0;
        line_active = 1'b0;
        row_sel     = 3'd0;
        digit_val   = 16'h0000;
        pix_en      = 1'b0;
        pat_row0    = 24'b011100_011100_011100_011100;
        pat_row2    = 24'b100010_100100_100110_101000;

        // Reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pix", pix_out, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_rom_digit", rom_digit, 4'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        // Basic fetch of 8888 at row 0
        start_line(1'b1, 3'd0, 16'h8888);
        for (int c = 0; c < 4; c++) begin
            check("t1_busy", busy, 1'b1);
            check("t1_done_low", done, 1'b0);
            check("t1_rom_digit", rom_digit, 4'd8);
            check("t1_rom_row", rom_row, 3'd0);
            step();
        end
        check("t1_busy_end", busy, 1'b0);
        check("t1_done", done, 1'b1);
        check("t1_rom_digit_idle", rom_digit, 4'd0);
        step();
        check("t1_done_pulse", done, 1'b0);
        for (int k = 0; k < 24; k++) pixel("t1_pix", pat_row0[23-k]);
        for (int k = 0; k < 4; k++) pixel("t1_pix_tail", 1'b0);
        check("t1_underrun", underrun, 1'b0);

        // Inactive line: buffer cleared, no fetch
        start_line(1'b0, 3'd0, 16'h8888);
        check("t2_busy", busy, 1'b0);
        check("t2_rom_digit", rom_digit, 4'd0);
        pix_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            check("t2_pix", pix_out, 1'b0);
            check("t2_busy_run", busy, 1'b0);
            check("t2_done_run", done, 1'b0);
            check("t2_rom_digit_run", rom_digit, 4'd0);
        end
        pix_en = 1'b0;

        // Restart during fetch with row 1
        start_line(1'b1, 3'd0, 16'h8888);
        step();
        step();
        line_start  = 1'b1;
        line_active = 1'b1;
        row_sel     = 3'd1;
        check("t3_done_abort", done, 1'b0);
        step();
        line_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("t3_busy", busy, 1'b1);
            check("t3_done_low", done, 1'b0);
            check("t3_rom_row", rom_row, 3'd1);
            step();
        end
        check("t3_done", done, 1'b1);
        step();
        check("t3_done_pulse", done, 1'b0);
        pixel("t3_pix0", 1'b1);
        pixel("t3_pix1", 1'b0);
        pixel("t3_pix2", 1'b0);
        pixel("t3_pix3", 1'b0);
        pixel("t3_pix4", 1'b1);

        // line_start and pix_en together in READY
        pix_en      = 1'b1;
        line_start  = 1'b1;
        line_active = 1'b1;
        row_sel     = 3'd2;
        digit_val   = 16'h4321;
        step();
        line_start = 1'b0;
        pix_en     = 1'b0;
        check("t4_pix_cleared", pix_out, 1'b0);
        check("t4_underrun", underrun, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check("t4_busy", busy, 1'b1);
            check("t4_rom_digit", rom_digit, 32'(c + 1));
            check("t4_rom_row", rom_row, 3'd2);
            step();
        end
        check("t4_done", done, 1'b1);
        for (int k = 0; k < 24; k++) pixel("t4_pix", pat_row2[23-k]);
        pixel("t4_pix_tail", 1'b0);

        // pix_en during fetch raises sticky underrun
        start_line(1'b1, 3'd0, 16'h8888);
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        check("t5_underrun", underrun, 1'b1);
        check("t5_pix", pix_out, 1'b0);
        for (int c = 0; c < 4; c++) step();
        start_line(1'b0, 3'd0, 16'h8888);
        step();
        check("t5_underrun_sticky", underrun, 1'b1);

        // Asynchronous reset mid-fetch
        start_line(1'b1, 3'd0, 16'h8888);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_underrun", underrun, 1'b0);
        check("t6_pix", pix_out, 1'b0);
        check("t6_rom_digit", rom_digit, 4'd0);
        check("t6_rom_row", rom_row, 3'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t6_idle_busy", busy, 1'b0);
        check("t6_idle_done", done, 1'b0);
        start_line(1'b1, 3'd0, 16'h8888);
        for (int c = 0; c < 4; c++) begin
            check("t6_busy_refetch", busy, 1'b1);
            step();
        end
        check("t6_done_refetch", done, 1'b1);
        for (int k = 0; k < 6; k++) pixel("t6_pix", pat_row0[23-k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
